// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and the MEM/WB register layout for the memory stage.
// Both the stage top and its bus interface import this package.
package mem_stage_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int WORD_ADDR_W = 30;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;
   localparam int REG_ADDR_W  = 5;
   localparam int ISA_EXP_W   = 3;

   typedef enum logic [MEM_OP_W-1:0] {
      MEM_OP_NOP = 2'd0,
      MEM_OP_LDW = 2'd1,
      MEM_OP_STW = 2'd2,
      MEM_OP_RSV = 2'd3
   } mem_op_e;

   typedef enum logic [1:0] {
      BUS_IF_STATE_IDLE   = 2'd0,
      BUS_IF_STATE_REQ    = 2'd1,
      BUS_IF_STATE_ACCESS = 2'd2,
      BUS_IF_STATE_STALL  = 2'd3
   } bus_if_state_e;

   localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP        = 2'd0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;

   typedef struct packed {
      logic [WORD_ADDR_W-1:0] pc;
      logic                   en;
      logic                   br_flag;
      logic [CTRL_OP_W-1:0]   ctrl_op;
      logic [REG_ADDR_W-1:0]  dst_addr;
      logic                   gpr_we_n;
      logic [ISA_EXP_W-1:0]   exp_code;
      logic [WORD_DATA_W-1:0] out;
   } mem_wb_t;

   // Bubble value: used both at reset and on flush.
   function automatic mem_wb_t mem_wb_bubble();
      mem_wb_t b;
      b          = '0;
      b.gpr_we_n = 1'b1;
      b.ctrl_op  = CTRL_OP_NOP;
      b.exp_code = ISA_EXP_NO_EXP;
      return b;
   endfunction

   function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
      return (op == MEM_OP_LDW) || (op == MEM_OP_STW);
   endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// Bus request/grant/ready sequencer for word loads and stores, plus the
// stage-result mux that selects live bus data, buffered data or the ALU value.
module mem_stage_bus_if
   import mem_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall_i,
   input  logic                   acc_i,
   input  logic                   ld_i,
   input  logic                   miss_align_i,
   input  logic [WORD_ADDR_W-1:0] addr_i,
   input  logic [WORD_DATA_W-1:0] wr_data_i,
   input  logic [WORD_DATA_W-1:0] ex_out_i,
   output logic                   busy_o,
   output logic [WORD_DATA_W-1:0] result_o,
   input  logic [WORD_DATA_W-1:0] bus_rd_data_i,
   input  logic                   bus_rdy_n_i,
   input  logic                   bus_grnt_n_i,
   output logic                   bus_req_n_o,
   output logic [WORD_ADDR_W-1:0] bus_addr_o,
   output logic                   bus_as_n_o,
   output logic                   bus_rw_o,
   output logic [WORD_DATA_W-1:0] bus_wr_data_o
);

   bus_if_state_e          state_q;
   logic                   req_n_q;
   logic                   as_n_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic                   rw_q;
   logic [WORD_DATA_W-1:0] wr_data_q;
   logic [WORD_DATA_W-1:0] rd_buf_q;

   // Address/rw/data are only non-zero during the single strobe cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BUS_IF_STATE_IDLE;
         req_n_q   <= 1'b1;
         as_n_q    <= 1'b1;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         wr_data_q <= '0;
         rd_buf_q  <= '0;
      end else begin
         case (state_q)
            BUS_IF_STATE_IDLE: begin
               if (acc_i) begin
                  req_n_q <= 1'b0;
                  state_q <= BUS_IF_STATE_REQ;
               end
            end
            BUS_IF_STATE_REQ: begin
               if (!bus_grnt_n_i) begin
                  as_n_q    <= 1'b0;
                  addr_q    <= addr_i;
                  rw_q      <= ld_i;
                  wr_data_q <= wr_data_i;
                  state_q   <= BUS_IF_STATE_ACCESS;
               end
            end
            BUS_IF_STATE_ACCESS: begin
               as_n_q    <= 1'b1;
               addr_q    <= '0;
               rw_q      <= 1'b0;
               wr_data_q <= '0;
               if (!bus_rdy_n_i) begin
                  req_n_q  <= 1'b1;
                  rd_buf_q <= bus_rd_data_i;
                  state_q  <= stall_i ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
               end
            end
            default: begin
               if (!stall_i) state_q <= BUS_IF_STATE_IDLE;
            end
         endcase
      end
   end

   // STALL holds the finished result without raising busy, so nothing re-issues.
   always_comb begin
      busy_o   = 1'b0;
      result_o = ex_out_i;
      case (state_q)
         BUS_IF_STATE_IDLE:   busy_o = acc_i;
         BUS_IF_STATE_REQ:    busy_o = 1'b1;
         BUS_IF_STATE_ACCESS: begin
            if (bus_rdy_n_i)  busy_o   = 1'b1;
            else if (ld_i)    result_o = bus_rd_data_i;
         end
         default: begin
            if (ld_i) result_o = rd_buf_q;
         end
      endcase
      if (miss_align_i) result_o = '0;
   end

   assign bus_req_n_o   = req_n_q;
   assign bus_as_n_o    = as_n_q;
   assign bus_addr_o    = addr_q;
   assign bus_rw_o      = rw_q;
   assign bus_wr_data_o = wr_data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: alignment check, bus sequencing via
// mem_stage_bus_if, and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   busy,
   output logic [WORD_DATA_W-1:0] fwd_data,
   input  logic [WORD_ADDR_W-1:0] ex_pc,
   input  logic                   ex_en,
   input  logic                   ex_br_flag,
   input  logic [MEM_OP_W-1:0]    ex_mem_op,
   input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   input  logic [CTRL_OP_W-1:0]   ex_ctrl_op,
   input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
   input  logic                   ex_gpr_we_,
   input  logic [ISA_EXP_W-1:0]   ex_exp_code,
   input  logic [WORD_DATA_W-1:0] ex_out,
   input  logic [WORD_DATA_W-1:0] bus_rd_data,
   input  logic                   bus_rdy_,
   input  logic                   bus_grnt_,
   output logic                   bus_req_,
   output logic [WORD_ADDR_W-1:0] bus_addr,
   output logic                   bus_as_,
   output logic                   bus_rw,
   output logic [WORD_DATA_W-1:0] bus_wr_data,
   output logic [WORD_ADDR_W-1:0] mem_pc,
   output logic                   mem_en,
   output logic                   mem_br_flag,
   output logic [CTRL_OP_W-1:0]   mem_ctrl_op,
   output logic [REG_ADDR_W-1:0]  mem_dst_addr,
   output logic                   mem_gpr_we_,
   output logic [ISA_EXP_W-1:0]   mem_exp_code,
   output logic [WORD_DATA_W-1:0] mem_out
);

   logic    mem_op;
   logic    miss_align;
   logic    acc;
   logic    ld;
   mem_wb_t mem_wb_d;
   mem_wb_t mem_wb_q;

   assign mem_op     = ex_en & is_mem_op(ex_mem_op);
   assign miss_align = mem_op & (ex_out[1:0] != 2'b00);
   assign acc        = mem_op & ~miss_align;
   assign ld         = (ex_mem_op == MEM_OP_LDW);

   mem_stage_bus_if u_bus_if (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall),
      .acc_i         (acc),
      .ld_i          (ld),
      .miss_align_i  (miss_align),
      .addr_i        (ex_out[WORD_DATA_W-1:2]),
      .wr_data_i     (ex_mem_wr_data),
      .ex_out_i      (ex_out),
      .busy_o        (busy),
      .result_o      (fwd_data),
      .bus_rd_data_i (bus_rd_data),
      .bus_rdy_n_i   (bus_rdy_),
      .bus_grnt_n_i  (bus_grnt_),
      .bus_req_n_o   (bus_req_),
      .bus_addr_o    (bus_addr),
      .bus_as_n_o    (bus_as_),
      .bus_rw_o      (bus_rw),
      .bus_wr_data_o (bus_wr_data)
   );

   // Flush wins over everything but is itself held off by stall.
   always_comb begin
      mem_wb_d = mem_wb_q;
      if (!stall) begin
         if (flush) begin
            mem_wb_d = mem_wb_bubble();
         end else begin
            mem_wb_d.pc       = ex_pc;
            mem_wb_d.en       = ex_en;
            mem_wb_d.br_flag  = ex_br_flag;
            mem_wb_d.ctrl_op  = ex_ctrl_op;
            mem_wb_d.dst_addr = ex_dst_addr;
            mem_wb_d.gpr_we_n = ex_gpr_we_;
            mem_wb_d.exp_code = ex_exp_code;
            mem_wb_d.out      = fwd_data;
            if (miss_align) begin
               mem_wb_d.ctrl_op  = CTRL_OP_NOP;
               mem_wb_d.gpr_we_n = 1'b1;
               mem_wb_d.exp_code = ISA_EXP_MISS_ALIGN;
               mem_wb_d.out      = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) mem_wb_q <= mem_wb_bubble();
      else       mem_wb_q <= mem_wb_d;
   end

   assign mem_pc       = mem_wb_q.pc;
   assign mem_en       = mem_wb_q.en;
   assign mem_br_flag  = mem_wb_q.br_flag;
   assign mem_ctrl_op  = mem_wb_q.ctrl_op;
   assign mem_dst_addr = mem_wb_q.dst_addr;
   assign mem_gpr_we_  = mem_wb_q.gpr_we_n;
   assign mem_exp_code = mem_wb_q.exp_code;
   assign mem_out      = mem_wb_q.out;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a transaction-level bus slave and instruction model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset, ext_stall, stall, flush, busy;
   logic [31:0] fwd_data;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag, ex_gpr_we_;
   logic [1:0]  ex_mem_op, ex_ctrl_op;
   logic [31:0] ex_mem_wr_data, ex_out;
   logic [4:0]  ex_dst_addr;
   logic [2:0]  ex_exp_code;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_, bus_grnt_, bus_req_, bus_as_, bus_rw;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data;
   logic [29:0] mem_pc;
   logic        mem_en, mem_br_flag, mem_gpr_we_;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   // The pipeline controller stalls whenever the stage reports busy.
   assign stall = busy | ext_stall;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
      .fwd_data(fwd_data), .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
      .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
      .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
      .ex_out(ex_out), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
      .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr),
      .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
      .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
      .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out)
   );

   typedef struct {
      logic [29:0] pc;
      logic        en, br, we_;
      logic [1:0]  op, ctrl;
      logic [31:0] wd, out;
      logic [4:0]  dst;
      logic [2:0]  exp;
   } instr_t;

   int          total = 0, passed = 0;
   int          as_cnt, busy_cnt, req_cnt;
   logic [29:0] rec_addr;
   logic        rec_rw;
   logic [31:0] rec_wd, ld;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic instr_t mk(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wd);
      instr_t i;
      i.pc = 30'($urandom); i.en = 1'b1; i.br = 1'($urandom); i.we_ = (op == 2'd2);
      i.op = op; i.ctrl = 2'($urandom); i.wd = wd; i.out = out;
      i.dst = 5'($urandom); i.exp = 3'd0;
      return i;
   endfunction

   // Drives one instruction until the MEM/WB register takes it. Slave waits:
   // gw cycles before grant, rw wait states after the strobe. hold = external
   // stall cycles once busy drops; fmode 1 = flush throughout, 2 = flush from strobe.
   task automatic run_instr(input instr_t in, input int gw, input int rw,
                            input logic [31:0] rdat, input int hold, input int fmode);
      logic memop, mis, acc, done, rdy_now, upd, fl;
      logic [31:0] res;
      int gcnt, rcnt, held;
      memop = in.en && (in.op == 2'd1 || in.op == 2'd2);
      mis   = memop && (in.out[1:0] != 2'b00);
      acc   = memop && !mis;
      ex_pc = in.pc; ex_en = in.en; ex_br_flag = in.br; ex_mem_op = in.op;
      ex_mem_wr_data = in.wd; ex_ctrl_op = in.ctrl; ex_dst_addr = in.dst;
      ex_gpr_we_ = in.we_; ex_exp_code = in.exp; ex_out = in.out;
      flush = (fmode == 1);
      gcnt = gw; rcnt = 0; held = 0; done = 1'b0; fl = 1'b0; res = '0;
      as_cnt = 0; busy_cnt = 0; req_cnt = 0; ld = '0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         rdy_now = 1'b0;
         if (bus_req_) begin
            bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
         end else if (!bus_as_) begin
            bus_grnt_ = 1'b1; as_cnt++;
            rec_addr = bus_addr; rec_rw = bus_rw; rec_wd = bus_wr_data;
            rcnt = rw;
            if (rcnt == 0) rdy_now = 1'b1; else rcnt--;
         end else if (as_cnt == 0) begin
            if (gcnt == 0) bus_grnt_ = 1'b0; else begin bus_grnt_ = 1'b1; gcnt--; end
         end else begin
            if (rcnt == 0) rdy_now = 1'b1; else rcnt--;
         end
         bus_rdy_ = !rdy_now;
         bus_rd_data = rdy_now ? rdat : $urandom();
         if (rdy_now) ld = rdat;
         if (fmode == 2 && as_cnt > 0) flush = 1'b1;
         #1;
         if (!busy && held < hold) begin ext_stall = 1'b1; held++; end
         else ext_stall = 1'b0;
         @(negedge clk);
         chk("busy", busy, acc && !done && !rdy_now);
         chk("bus_req_", bus_req_, !(acc && cyc >= 1 && !done));
         if (!bus_req_) req_cnt++;
         if (busy) busy_cnt++;
         if (bus_as_) chk("bus_idle_fields", {bus_addr, bus_rw, bus_wr_data}, 63'd0);
         else begin
            chk("as_addr", bus_addr, in.out[31:2]);
            chk("as_rw", bus_rw, in.op == 2'd1);
            chk("as_wd", bus_wr_data, in.wd);
         end
         upd = !stall;
         if (upd) begin
            res = mis ? 32'd0 : (acc && in.op == 2'd1) ? ld : in.out;
            chk("fwd_data", fwd_data, res);
            fl = flush;
         end
         @(posedge clk); #1;
         if (rdy_now) done = 1'b1;
         if (upd) begin
            if (fl) begin
               chk("fl_en", mem_en, 0); chk("fl_we_", mem_gpr_we_, 1);
               chk("fl_ctrl", mem_ctrl_op, 0); chk("fl_exp", mem_exp_code, 0);
               chk("fl_br", mem_br_flag, 0); chk("fl_out", mem_out, 0);
            end else begin
               chk("mem_pc", mem_pc, in.pc); chk("mem_en", mem_en, in.en);
               chk("mem_br", mem_br_flag, in.br); chk("mem_dst", mem_dst_addr, in.dst);
               chk("mem_we_", mem_gpr_we_, mis ? 1'b1 : in.we_);
               chk("mem_exp", mem_exp_code, mis ? 3'd4 : in.exp);
               chk("mem_out", mem_out, res);
               if (!mis) chk("mem_ctrl", mem_ctrl_op, in.ctrl);
            end
            chk("as_pulses", as_cnt, acc ? 1 : 0);
            ext_stall = 1'b0; flush = 1'b0;
            return;
         end
      end
      chk("retire_timeout", 0, 1);
      ext_stall = 1'b0; flush = 1'b0;
   endtask

   initial begin
      instr_t in;
      reset = 1'b1; ext_stall = 1'b0; flush = 1'b0;
      ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_mem_op = '0; ex_mem_wr_data = '0;
      ex_ctrl_op = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = '0; ex_out = '0;
      bus_rd_data = '0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_", bus_req_, 1); chk("rst_as_", bus_as_, 1); chk("rst_busy", busy, 0);
      chk("rst_en", mem_en, 0); chk("rst_we_", mem_gpr_we_, 1);
      chk("rst_exp", mem_exp_code, 0); chk("rst_out", mem_out, 0); chk("rst_pc", mem_pc, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      in = mk(2'd0, 32'h1234, 32'h0); in.dst = 5'd3; in.we_ = 1'b0;
      run_instr(in, 0, 0, 32'h0, 0, 0);
      chk("add_out", mem_out, 32'h1234); chk("add_dst", mem_dst_addr, 5'd3);
      chk("add_we_", mem_gpr_we_, 0); chk("add_busy_cnt", busy_cnt, 0);

      in = mk(2'd1, 32'h100, 32'h0);
      run_instr(in, 0, 0, 32'hDEADBEEF, 0, 0);
      chk("ldw_addr", rec_addr, 30'h40); chk("ldw_rw", rec_rw, 1);
      chk("ldw_busy_cnt", busy_cnt, 2); chk("ldw_out", mem_out, 32'hDEADBEEF);

      in = mk(2'd2, 32'h200, 32'hA5A5A5A5);
      run_instr(in, 0, 2, 32'h0, 0, 0);
      chk("stw_wd", rec_wd, 32'hA5A5A5A5); chk("stw_rw", rec_rw, 0);
      chk("stw_as_cnt", as_cnt, 1); chk("stw_busy_cnt", busy_cnt, 4);

      in = mk(2'd1, 32'h102, 32'h0);
      run_instr(in, 0, 0, 32'h0, 0, 0);
      chk("mis_exp", mem_exp_code, 3'd4); chk("mis_we_", mem_gpr_we_, 1);
      chk("mis_req_cnt", req_cnt, 0); chk("mis_out", mem_out, 0);

      in = mk(2'd1, 32'h80, 32'h0);
      run_instr(in, 1, 1, 32'h13579BDF, 3, 0);
      chk("stl_out", mem_out, 32'h13579BDF); chk("stl_as_cnt", as_cnt, 1);

      in = mk(2'd1, 32'h44, 32'h0);
      run_instr(in, 0, 1, 32'h2468ACE0, 0, 2);
      chk("fls_en", mem_en, 0); chk("fls_we_", mem_gpr_we_, 1); chk("fls_as_cnt", as_cnt, 1);

      // Reset while the request is outstanding and not yet granted.
      ex_en = 1'b1; ex_mem_op = 2'd1; ex_out = 32'h300; ex_gpr_we_ = 1'b0;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
      @(posedge clk); #1;
      chk("rq_req_low", bus_req_, 0);
      @(negedge clk);
      reset = 1'b1; ex_en = 1'b0;
      @(posedge clk); #1;
      chk("rq_req_", bus_req_, 1); chk("rq_as_", bus_as_, 1); chk("rq_busy", busy, 0);
      chk("rq_en", mem_en, 0); chk("rq_we_", mem_gpr_we_, 1); chk("rq_exp", mem_exp_code, 0);
      chk("rq_out", mem_out, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rq_idle_req_", bus_req_, 1);

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         in = mk(2'($urandom_range(0, 3)), a, $urandom());
         in.en = ($urandom_range(0, 9) != 0);
         in.exp = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
         run_instr(in, $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 6) == 0) ? $urandom_range(1, 2) : 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
